// File: rtl/sqrt_arbiter.sv
// sqrt_arbiter: round-robin arbiter over four requesters feeding a shared
// iterative integer square-root unit (odd-number accumulation).
// Optional feature: define SQRT_ARBITER_ZERO_BYPASS_EN to send a zero
// operand straight from IDLE to DONE, so vld_o rises with gnt_o.
module sqrt_arbiter #(
    parameter int unsigned NREQ = 4
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic [NREQ-1:0]     req_i,
    input  logic [8*NREQ-1:0]   dt_i,
    output logic [NREQ-1:0]     gnt_o,
    output logic                busy_o,
    output logic                vld_o,
    output logic [7:0]          res_o,
    output logic [1:0]          id_o,
    input  logic                rdy_i
);

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            vld_q, vld_d;
    logic [7:0]      res_q, res_d;
    logic [1:0]      id_q, id_d;
    logic [7:0]      x_q, x_d;
    logic [3:0]      r_q, r_d;
    // sq holds (r+1)^2; reaches 256 for x=255, hence 9 bits
    logic [8:0]      sq_q, sq_d;
    // Index with top priority in the next arbitration round
    logic [1:0]      prio_q, prio_d;

    logic            win_found;
    logic [1:0]      win_idx;
    logic [1:0]      cand;
    logic [7:0]      win_op;

    // Round-robin search starting at the priority pointer
    always_comb begin
        win_found = 1'b0;
        win_idx   = 2'd0;
        cand      = 2'd0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = prio_q + 2'(i);
            if (!win_found && req_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign win_op = dt_i[{win_idx, 3'b000} +: 8];

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        gnt_d   = '0;
        vld_d   = vld_q;
        res_d   = res_q;
        id_d    = id_q;
        x_d     = x_q;
        r_d     = r_q;
        sq_d    = sq_q;
        prio_d  = prio_q;
        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    gnt_d[win_idx] = 1'b1;
                    id_d           = win_idx;
                    x_d            = win_op;
                    r_d            = 4'd0;
                    sq_d           = 9'd1;
                    prio_d         = win_idx + 2'd1;
`ifdef SQRT_ARBITER_ZERO_BYPASS_EN
                    if (win_op == 8'd0) begin
                        res_d   = 8'd0;
                        vld_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        state_d = StCalc;
                    end
`else
                    state_d = StCalc;
`endif
                end
            end
            StCalc: begin
                if (sq_q <= {1'b0, x_q}) begin
                    // (r+2)^2 = (r+1)^2 + 2r + 3
                    r_d  = r_q + 4'd1;
                    sq_d = sq_q + {4'd0, r_q, 1'b0} + 9'd3;
                end else begin
                    res_d   = {4'd0, r_q};
                    vld_d   = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (rdy_i) begin
                    vld_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            vld_q   <= 1'b0;
            res_q   <= 8'd0;
            id_q    <= 2'd0;
            x_q     <= 8'd0;
            r_q     <= 4'd0;
            sq_q    <= 9'd1;
            prio_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            vld_q   <= vld_d;
            res_q   <= res_d;
            id_q    <= id_d;
            x_q     <= x_d;
            r_q     <= r_d;
            sq_q    <= sq_d;
            prio_q  <= prio_d;
        end
    end

    assign gnt_o  = gnt_q;
    assign vld_o  = vld_q;
    assign res_o  = res_q;
    assign id_o   = id_q;
    assign busy_o = (state_q != StIdle);

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Self-checking bench for sqrt_arbiter: vector table of single requests,
// round-robin, backpressure and mid-operation reset sequences.
module tb_sqrt_arbiter;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic [3:0]  req_i;
    logic [31:0] dt_i;
    logic [3:0]  gnt_o;
    logic        busy_o;
    logic        vld_o;
    logic [7:0]  res_o;
    logic [1:0]  id_o;
    logic        rdy_i;

    sqrt_arbiter #(.NREQ(4)) dut (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .req_i  (req_i),
        .dt_i   (dt_i),
        .gnt_o  (gnt_o),
        .busy_o (busy_o),
        .vld_o  (vld_o),
        .res_o  (res_o),
        .id_o   (id_o),
        .rdy_i  (rdy_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0] id;
        logic [7:0] op;
        logic [7:0] res;
    } vec_t;

    typedef struct {
        logic [7:0] res;
        logic [1:0] id;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[10];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [7:0] op, input logic [7:0] res);
        int l;
        l = int'(res) + 1;
`ifdef SQRT_ARBITER_ZERO_BYPASS_EN
        if (op == 8'd0) l = 0;
`else
        if (op == 8'd0) l = 1;
`endif
        return l;
    endfunction

    // Compare the current result against the oldest expectation
    task automatic sb_pop_check(input string name);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: result res=%0d id=%0d with no expectation queued", name, res_o,
                     id_o);
        end else begin
            e = sb.pop_front();
            check({name, "_res"}, res_o, e.res);
            check({name, "_id"}, id_o, e.id);
        end
    endtask

    task automatic wait_gnt(input string name, input logic [3:0] exp_gnt);
        int n;
        n = 0;
        while (gnt_o == 4'd0 && n < 64) begin
            @(negedge clk_i);
            n++;
        end
        check({name, "_gnt"}, gnt_o, exp_gnt);
    endtask

    task automatic wait_vld(output int lat);
        lat = 0;
        while (!vld_o && lat < 64) begin
            @(negedge clk_i);
            lat++;
        end
    endtask

    task automatic do_reset();
        rstn_i = 1'b0;
        req_i  = 4'd0;
        dt_i   = 32'd0;
        rdy_i  = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        check("rst_gnt", gnt_o, 0);
        check("rst_vld", vld_o, 0);
        check("rst_res", res_o, 0);
        check("rst_id", id_o, 0);
        check("rst_busy", busy_o, 0);
        rstn_i = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic run_one(input vec_t v);
        int lat;
        logic [3:0] eg;
        eg = 4'b0001 << v.id;
        req_i = eg;
        dt_i = 32'd0;
        dt_i[int'(v.id)*8 +: 8] = v.op;
        sb.push_back('{res: v.res, id: v.id});
        @(negedge clk_i);
        wait_gnt($sformatf("vec_op%0d", v.op), eg);
        req_i = 4'd0;
        wait_vld(lat);
        check($sformatf("vec_op%0d_lat", v.op), lat, exp_lat(v.op, v.res));
        sb_pop_check($sformatf("vec_op%0d", v.op));
        check($sformatf("vec_op%0d_busy", v.op), busy_o, 1);
        @(negedge clk_i);
        check($sformatf("vec_op%0d_vld_pulse", v.op), vld_o, 0);
        check($sformatf("vec_op%0d_idle", v.op), busy_o, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   lat;
        logic seen;

        vecs[0] = '{2'd0, 8'd81, 8'd9};
        vecs[1] = '{2'd1, 8'd0, 8'd0};
        vecs[2] = '{2'd2, 8'd1, 8'd1};
        vecs[3] = '{2'd3, 8'd3, 8'd1};
        vecs[4] = '{2'd0, 8'd4, 8'd2};
        vecs[5] = '{2'd1, 8'd15, 8'd3};
        vecs[6] = '{2'd2, 8'd16, 8'd4};
        vecs[7] = '{2'd3, 8'd255, 8'd15};
        vecs[8] = '{2'd1, 8'd100, 8'd10};
        vecs[9] = '{2'd2, 8'd224, 8'd14};

        do_reset();

        for (int i = 0; i < 10; i++) begin
            run_one(vecs[i]);
        end

        // Round-robin with all requesters held
        do_reset();
        req_i = 4'hF;
        dt_i  = {8'd25, 8'd16, 8'd9, 8'd4};
        for (int k = 0; k < 5; k++) begin
            sb.push_back('{res: 8'(k % 4 + 2), id: 2'(k % 4)});
        end
        for (int k = 0; k < 5; k++) begin
            wait_gnt($sformatf("rr%0d", k), 4'b0001 << (k % 4));
            wait_vld(lat);
            sb_pop_check($sformatf("rr%0d", k));
            @(negedge clk_i);
            check($sformatf("rr%0d_idle_gap", k), busy_o, 0);
            check($sformatf("rr%0d_gap_gnt", k), gnt_o, 0);
            if (k == 4) req_i = 4'd0;
        end

        // Backpressure with a competing request that must be ignored
        rdy_i = 1'b0;
        req_i = 4'b0100;
        dt_i  = 32'd0;
        dt_i[23:16] = 8'd49;
        sb.push_back('{res: 8'd7, id: 2'd2});
        @(negedge clk_i);
        wait_gnt("bp", 4'b0100);
        req_i = 4'b0010;
        dt_i[15:8] = 8'd5;
        wait_vld(lat);
        check("bp_lat", lat, 8);
        sb_pop_check("bp");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check($sformatf("bp_hold%0d_vld", i), vld_o, 1);
            check($sformatf("bp_hold%0d_res", i), res_o, 7);
            check($sformatf("bp_hold%0d_id", i), id_o, 2);
            check($sformatf("bp_hold%0d_busy", i), busy_o, 1);
            check($sformatf("bp_hold%0d_gnt", i), gnt_o, 0);
        end
        req_i = 4'd0;
        rdy_i = 1'b1;
        @(negedge clk_i);
        check("bp_release_vld", vld_o, 0);
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            if (gnt_o != 4'd0) seen = 1'b1;
        end
        check("bp_dropped_req_no_gnt", seen, 0);

        // Reset in the middle of a long computation
        req_i = 4'b0010;
        dt_i  = 32'd0;
        dt_i[15:8] = 8'd200;
        @(negedge clk_i);
        wait_gnt("rstcalc", 4'b0010);
        req_i = 4'd0;
        @(negedge clk_i);
        @(negedge clk_i);
        check("rstcalc_busy_before", busy_o, 1);
        rstn_i = 1'b0;
        #1;
        check("rstcalc_gnt", gnt_o, 0);
        check("rstcalc_vld", vld_o, 0);
        check("rstcalc_res", res_o, 0);
        check("rstcalc_id", id_o, 0);
        check("rstcalc_busy", busy_o, 0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk_i);
            if (vld_o) seen = 1'b1;
        end
        check("rstcalc_no_vld", seen, 0);

        check("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sqrt_arbiter.md
SQRT_ARBITER -- requirements
Module: sqrt_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, giving the number of requesters; only the value 4 is supported.
REQ-002 Port clk_i, input, 1 bit, SHALL be the single clock; all state changes on its rising edge.
REQ-003 Port rstn_i, input, 1 bit, SHALL be the reset, asynchronous and active-low.
REQ-004 Port req_i, input, 4 bits, SHALL carry the per-requester request level; bit n belongs to requester n.
REQ-005 Port dt_i, input, 32 bits, SHALL carry the packed operands; bits [8n+7:8n] belong to requester n and are held stable while req_i[n] is high.
REQ-006 Port gnt_o, output, 4 bits, SHALL be a registered one-hot pulse marking the operand capture for the granted requester.
REQ-007 Port busy_o, output, 1 bit, SHALL be high in every state except IDLE.
REQ-008 Port vld_o, output, 1 bit, SHALL flag a valid result on res_o and id_o.
REQ-009 Port res_o, output, 8 bits, SHALL carry floor(sqrt(operand)), zero-extended from 4 bits.
REQ-010 Port id_o, output, 2 bits, SHALL carry the index of the requester that owns res_o.
REQ-011 Port rdy_i, input, 1 bit, SHALL be the consumer acknowledge; a result transfers on a cycle where vld_o and rdy_i are both high.

Function
REQ-012 The FSM SHALL have the states IDLE, CALC and DONE.
REQ-013 In IDLE, the first clock edge with req_i non-zero SHALL select a winner round-robin, starting at index (last granted + 1) mod 4.
REQ-014 That same edge SHALL capture the winner's operand into an 8-bit register x, latch its id, set gnt_o to the winner's bit for exactly one cycle, set r=0 and sq=1 (9 bits), and move to CALC.
REQ-015 In CALC, each cycle with sq <= x SHALL update r <= r+1 and sq <= sq + 2r + 3; the cycle with sq > x SHALL load res_o <= r and move to DONE.
REQ-016 vld_o SHALL rise floor(sqrt(x))+1 cycles after the grant edge: 1 cycle for x=0, 16 cycles for x=255.
REQ-017 sq SHALL be 9 bits wide, so that the maximum value 256 does not overflow; r SHALL be 4 bits wide.
REQ-018 In DONE, vld_o, res_o and id_o SHALL stay stable until rdy_i is high; the edge with rdy_i high SHALL clear vld_o and return to IDLE.
REQ-019 If rdy_i is already high on entry to DONE, vld_o SHALL be high for exactly one cycle.
REQ-020 req_i SHALL be ignored outside IDLE; a request dropped before its grant edge SHALL receive no grant.
REQ-021 After an acknowledge, the block SHALL spend at least one cycle in IDLE before the next grant, so back-to-back requests see a gap of one or more cycles.
REQ-022 A requester whose req_i stays high after its grant SHALL be granted again only after every other active requester has been granted.

Reset
REQ-023 While rstn_i is low, the block SHALL set state=IDLE, gnt_o=0, vld_o=0, res_o=0, id_o=0, busy_o=0, x=0, r=0, sq=1, and set the round-robin pointer so that requester 0 has top priority.
REQ-024 Reset asserted mid-CALC or in DONE SHALL abort the operation and discard the result; no vld_o SHALL follow the release of reset.

Configuration
REQ-025 When the macro SQRT_ARBITER_ZERO_BYPASS_EN is defined, a captured operand of 0 SHALL go from IDLE straight to DONE with res_o=0, so vld_o is high in the same cycle as gnt_o.
REQ-026 When SQRT_ARBITER_ZERO_BYPASS_EN is undefined, a zero operand SHALL pass through one CALC cycle, per REQ-015 and REQ-016.

Verification
REQ-027 Single request: req_i=0001, dt_i[7:0]=81, rdy_i=1 -> gnt_o=0001 for 1 cycle; 10 cycles later vld_o=1, res_o=9, id_o=0.
REQ-028 Boundaries: operands 0, 1, 3, 4, 15, 16, 255 -> res_o values 0, 1, 1, 2, 3, 4, 15; latencies per REQ-016/REQ-025.
REQ-029 Round-robin: req_i=1111 held, operands 4/9/16/25, rdy_i=1 -> grant order 0,1,2,3,0, with res_o 2,3,4,5 and matching id_o.
REQ-030 Backpressure: rdy_i=0 for 5 cycles in DONE with result 7 (x=49) -> vld_o, res_o=7 and id_o stay stable for all 5 cycles; busy_o=1; no new grant.
REQ-031 Reset mid-CALC: assert rstn_i low on cycle 3 of x=200 -> all outputs 0 at once; after release, with req_i=0, no vld_o appears.
REQ-032 Zero bypass: x=0 with and without SQRT_ARBITER_ZERO_BYPASS_EN -> vld_o at the grant cycle versus 1 cycle later; res_o=0 in both cases.
